dut_slave_rsp: RTL and testbench

Slave-side responder for the cmd/adr/data bus of the 4-bit DUT interface. It consumes one command per `clk` edge from the `slave` modport signals and executes it against a 16 x 4-bit register file. Read results go to a response FIFO with a valid/ready handshake. It is the responding end for the interface's master driver and gives the covergroups real, stateful DUT behaviour to sample.

---
 rtl/dut_slave_rsp.sv | 224 ++++++++++++++++++++++
 tb/tb_dut_slave_rsp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dut_slave_rsp.sv
`default_nettype none
// ============================================================================
// Module      : dut_slave_rsp
// Description : Slave-side responder for the 4-bit cmd/adr/data bus. Executes
//               one command per clock against a 16 x 4-bit register file and
//               returns read results through a valid/ready response FIFO.
//               A CLR command starts a 16-cycle sweep that zeroes the register
//               file; commands arriving during the sweep are dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : RSP_DEPTH  response FIFO depth (power of two, 2..16)
//               ERR_W      width of the saturating err/drop counters
// Ports       : clk        clock, all state updates on posedge
//               rst        asynchronous active-high reset
//               cmd[3:0]   opcode (0 NOP, 1 WR, 2 RD, 3 INC, 4 CLR, else illegal)
//               adr[3:0]   register-file address
//               data[3:0]  write / increment operand
//               rsp_valid  FIFO head holds a read response
//               rsp_adr    address of the head response
//               rsp_data   data of the head response
//               rsp_ready  consumer accepts the head response
//               busy       clear sweep in progress
//               err_cnt    illegal-opcode count, saturating
//               drop_cnt   discarded-command count, saturating
// Build macro : DUT_SLAVE_RSP_INC_EN - when defined, opcode 3 performs INC;
//               otherwise opcode 3 is treated as illegal.
// ============================================================================
module dut_slave_rsp #(
   parameter int RSP_DEPTH = 4,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       cmd,
   input  logic [3:0]       adr,
   input  logic [3:0]       data,
   output logic             rsp_valid,
   output logic [3:0]       rsp_adr,
   output logic [3:0]       rsp_data,
   input  logic             rsp_ready,
   output logic             busy,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] drop_cnt
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [3:0]       c_op_nop  = 4'd0;
   localparam logic [3:0]       c_op_wr   = 4'd1;
   localparam logic [3:0]       c_op_rd   = 4'd2;
`ifdef DUT_SLAVE_RSP_INC_EN
   localparam logic [3:0]       c_op_inc  = 4'd3;
`endif
   localparam logic [3:0]       c_op_clr  = 4'd4;
   localparam logic [CNT_W-1:0] c_full    = CNT_W'(RSP_DEPTH);
   localparam logic [3:0]       c_idx_last = 4'd15;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       mem_q [16];
   logic [3:0]       mem_d [16];
   logic [3:0]       fifo_adr_q  [RSP_DEPTH];
   logic [3:0]       fifo_adr_d  [RSP_DEPTH];
   logic [3:0]       fifo_data_q [RSP_DEPTH];
   logic [3:0]       fifo_data_d [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_err_inc;
   logic             w_drop_inc;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mem_d       = mem_q;
      fifo_adr_d  = fifo_adr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      err_cnt_d   = err_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      w_push      = 1'b0;
      w_err_inc   = 1'b0;
      w_drop_inc  = 1'b0;

      w_pop  = (count_q != '0) && rsp_ready;
      w_full = (count_q == c_full);

      case (state_q)
         ST_IDLE: begin
            // Unknown opcode bits match no item and fall into the illegal
            // branch.
            case (cmd)
               c_op_nop: begin
               end
               c_op_wr: begin
                  mem_d[adr] = data;
               end
               c_op_rd: begin
                  // A full FIFO still takes the push when the head leaves on
                  // the same edge.
                  if (!w_full || w_pop) begin
                     w_push = 1'b1;
                  end else begin
                     w_drop_inc = 1'b1;
                  end
               end
`ifdef DUT_SLAVE_RSP_INC_EN
               c_op_inc: begin
                  mem_d[adr] = mem_q[adr] + data;
               end
`endif
               c_op_clr: begin
                  state_d = ST_CLEAR;
                  idx_d   = 4'd0;
               end
               default: begin
                  w_err_inc = 1'b1;
               end
            endcase
         end

         ST_CLEAR: begin
            mem_d[idx_q] = 4'd0;
            idx_d        = idx_q + 4'd1;
            if (idx_q == c_idx_last) begin
               state_d = ST_IDLE;
            end
            // Written as if/else so an unknown opcode counts as a drop.
            if (cmd == c_op_nop) begin
            end else begin
               w_drop_inc = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Response FIFO bookkeeping. Read data is the pre-edge mem content.
      if (w_push) begin
         fifo_adr_d[wr_ptr_q]  = adr;
         fifo_data_d[wr_ptr_q] = mem_q[adr];
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Saturating counters: hold at all-ones.
      if (w_err_inc && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
      if (w_drop_inc && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 4'd0;
         mem_q       <= '{default: 4'd0};
         fifo_adr_q  <= '{default: 4'd0};
         fifo_data_q <= '{default: 4'd0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mem_q       <= mem_d;
         fifo_adr_q  <= fifo_adr_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_cnt_q   <= err_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded straight from flops, independent of rsp_ready.
   // -------------------------------------------------------------------------
   assign rsp_valid = (count_q != '0);
   assign rsp_adr   = fifo_adr_q[rd_ptr_q];
   assign rsp_data  = fifo_data_q[rd_ptr_q];
   assign busy      = (state_q == ST_CLEAR);
   assign err_cnt   = err_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dut_slave_rsp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dut_slave_rsp
// Description : Directed self-checking bench for dut_slave_rsp. Inputs change
//               on the falling edge; outputs are sampled 1 ns after the rising
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dut_slave_rsp;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_WR  = 4'd1;
   localparam logic [3:0] OP_RD  = 4'd2;
   localparam logic [3:0] OP_INC = 4'd3;
   localparam logic [3:0] OP_CLR = 4'd4;
   localparam logic [3:0] OP_BAD = 4'd9;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cmd;
   logic [3:0] adr;
   logic [3:0] data;
   logic       rsp_valid;
   logic [3:0] rsp_adr;
   logic [3:0] rsp_data;
   logic       rsp_ready;
   logic       busy;
   logic [7:0] err_cnt;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   dut_slave_rsp #(
      .RSP_DEPTH (4),
      .ERR_W     (8)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (cmd),
      .adr       (adr),
      .data      (data),
      .rsp_valid (rsp_valid),
      .rsp_adr   (rsp_adr),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .busy      (busy),
      .err_cnt   (err_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one command on the falling edge, then return 1 ns after the
   // rising edge that samples it.
   task automatic cyc(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
      @(negedge clk);
      cmd  = c;
      adr  = a;
      data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cycles;
      logic [7:0] err_before;

      rst = 1'b1; cmd = OP_NOP; adr = 4'd0; data = 4'd0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", rsp_valid, 0);
      check_eq("rst_busy",  busy, 0);
      check_eq("rst_err",   err_cnt, 0);
      check_eq("rst_drop",  drop_cnt, 0);
      check_eq("rst_adr",   rsp_adr, 0);
      check_eq("rst_data",  rsp_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- write / read-back ----------------
      rsp_ready = 1'b1;
      cyc(OP_WR, 4'd5, 4'd9);
      check_eq("wr_no_rsp", rsp_valid, 0);
      cyc(OP_RD, 4'd5, 4'd0);
      check_eq("rd_valid", rsp_valid, 1);
      check_eq("rd_adr",   rsp_adr, 5);
      check_eq("rd_data",  rsp_data, 9);
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("rd_popped", rsp_valid, 0);

      // ---------------- increment wrap ----------------
      cyc(OP_WR,  4'd2, 4'd14);
      cyc(OP_INC, 4'd2, 4'd3);
      cyc(OP_RD,  4'd2, 4'd0);
`ifdef DUT_SLAVE_RSP_INC_EN
      check_eq("inc_data", rsp_data, 1);
      check_eq("inc_err",  err_cnt, 0);
`else
      check_eq("inc_data", rsp_data, 14);
      check_eq("inc_err",  err_cnt, 1);
`endif
      check_eq("inc_adr", rsp_adr, 2);
      cyc(OP_NOP, 4'd0, 4'd0);

      // ---------------- FIFO backpressure ----------------
      cyc(OP_WR, 4'd8,  4'd1);
      cyc(OP_WR, 4'd9,  4'd2);
      cyc(OP_WR, 4'd10, 4'd3);
      cyc(OP_WR, 4'd11, 4'd4);
      cyc(OP_WR, 4'd13, 4'd5);
      rsp_ready = 1'b0;
      cyc(OP_RD, 4'd8,  4'd0);
      cyc(OP_RD, 4'd9,  4'd0);
      cyc(OP_RD, 4'd10, 4'd0);
      cyc(OP_RD, 4'd11, 4'd0);
      check_eq("bp_nodrop", drop_cnt, 0);
      cyc(OP_RD, 4'd12, 4'd0);
      check_eq("bp_drop",   drop_cnt, 1);
      check_eq("bp_head_a", rsp_adr, 8);
      check_eq("bp_head_d", rsp_data, 1);
      // Full FIFO, pop and push on the same edge: push must be accepted.
      rsp_ready = 1'b1;
      cyc(OP_RD, 4'd13, 4'd0);
      check_eq("bp_swap_drop", drop_cnt, 1);
      check_eq("bp_h1_a", rsp_adr, 9);
      check_eq("bp_h1_d", rsp_data, 2);
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("bp_h2_a", rsp_adr, 10);
      check_eq("bp_h2_d", rsp_data, 3);
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("bp_h3_a", rsp_adr, 11);
      check_eq("bp_h3_d", rsp_data, 4);
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("bp_h4_a", rsp_adr, 13);
      check_eq("bp_h4_d", rsp_data, 5);
      check_eq("bp_h4_v", rsp_valid, 1);
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("bp_empty", rsp_valid, 0);

      // ---------------- clear sequence ----------------
      for (int i = 0; i < 16; i++) begin
         cyc(OP_WR, 4'(i), 4'hF);
      end
      cyc(OP_CLR, 4'd0, 4'd0);
      check_eq("clr_busy0", busy, 1);
      busy_cycles = 1;
      for (int i = 1; i <= 16; i++) begin
         if (i <= 3) begin
            cyc(OP_WR, 4'(i), 4'd7);
         end else begin
            cyc(OP_NOP, 4'd0, 4'd0);
         end
         if (busy) busy_cycles++;
      end
      check_eq("clr_busy_len", busy_cycles, 16);
      check_eq("clr_busy_end", busy, 0);
      // Previous drop plus the three WRs issued during the sweep.
      check_eq("clr_drop", drop_cnt, 4);
      // First command after the sweep executes.
      cyc(OP_WR, 4'd1, 4'd6);
      for (int i = 0; i < 16; i++) begin
         cyc(OP_RD, 4'(i), 4'd0);
         check_eq("clr_rd_v", rsp_valid, 1);
         check_eq("clr_rd_a", rsp_adr, i);
         check_eq("clr_rd_d", rsp_data, (i == 1) ? 6 : 0);
      end
      cyc(OP_NOP, 4'd0, 4'd0);
      check_eq("clr_drained", rsp_valid, 0);

      // ---------------- illegal opcodes / saturation ----------------
      err_before = err_cnt;
      for (int i = 0; i < 300; i++) begin
         cyc(OP_BAD, 4'(i), 4'hF);
      end
      check_eq("sat_err_pre", err_before, 0
`ifndef DUT_SLAVE_RSP_INC_EN
               + 1
`endif
               );
      check_eq("sat_err",  err_cnt, 255);
      check_eq("sat_drop", drop_cnt, 4);
      cyc(OP_RD, 4'd1, 4'd0);
      check_eq("sat_mem1", rsp_data, 6);
      cyc(OP_RD, 4'd0, 4'd0);
      check_eq("sat_mem0", rsp_data, 0);
      cyc(OP_NOP, 4'd0, 4'd0);

      // ---------------- reset mid-operation ----------------
      rsp_ready = 1'b0;
      cyc(OP_RD, 4'd1, 4'd0);
      cyc(OP_RD, 4'd1, 4'd0);
      cyc(OP_CLR, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(OP_NOP, 4'd0, 4'd0);
      end
      check_eq("mr_pre_busy",  busy, 1);
      check_eq("mr_pre_valid", rsp_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mr_busy",  busy, 0);
      check_eq("mr_valid", rsp_valid, 0);
      check_eq("mr_err",   err_cnt, 0);
      check_eq("mr_drop",  drop_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      cyc(OP_RD, 4'd1, 4'd0);
      check_eq("mr_rd1_v", rsp_valid, 1);
      check_eq("mr_rd1_d", rsp_data, 0);
      cyc(OP_RD, 4'd7, 4'd0);
      check_eq("mr_rd7_a", rsp_adr, 7);
      check_eq("mr_rd7_d", rsp_data, 0);
      cyc(OP_NOP, 4'd0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
